// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU.
//   mode_e  : operation selected with start (ADD, SUB, INC, NEG)
//   state_e : word sequencer state (IDLE, RUN)
package serial_alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_INC = 2'd2,
    MODE_NEG = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Maps a mode onto the full-adder x operand (a or ~a).
  function automatic logic op_x(input mode_e m, input logic a);
    return (m == MODE_NEG) ? ~a : a;
  endfunction

  // Maps a mode onto the full-adder y operand (b, ~b or 0).
  function automatic logic op_y(input mode_e m, input logic b);
    case (m)
      MODE_ADD: return b;
      MODE_SUB: return ~b;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_fa.sv
// Combinational full-adder cell.
//   x, y, cin : operand bits and carry in
//   s, cout   : sum bit and carry out
module serial_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ADD/SUB/INC/NEG unit, LSB first, one registered result bit per
// cycle with one cycle of latency.
//   clk, reset          : clock, synchronous active-high reset
//   start, mode         : word start strobe and operation (sampled with start)
//   a_in, b_in          : serial operands, bit 0 present with start
//   sum_out, out_valid  : registered serial result and its qualifier
//   busy                : word in progress, start ignored
//   done                : pulse with the last result bit
//   carry_out, overflow : word flags, updated with done and held
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; the accept cycle consumes bit 0
// ST_RUN  | consuming bits 1..WIDTH-1, start ignored
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       a_in,
  input  logic       b_in,
  output logic       sum_out,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       carry_out,
  output logic       overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_sum;
  logic             r_valid;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_consume;
  mode_e            w_mode;
  logic             w_x;
  logic             w_y;
  logic             w_cin;
  logic             w_s;
  logic             w_cout;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_consume = w_accept | (r_state == ST_RUN);

  // Bit 0 is consumed before the mode/carry registers are loaded, so the
  // accept cycle takes mode and carry-in straight from the inputs.
  assign w_mode = (r_state == ST_IDLE) ? mode_e'(mode) : r_mode;
  assign w_cin  = (r_state == ST_IDLE) ? (w_mode != MODE_ADD) : r_carry;
  assign w_x    = op_x(w_mode, a_in);
  assign w_y    = op_y(w_mode, b_in);

  serial_fa u_fa (
    .x    (w_x),
    .y    (w_y),
    .cin  (w_cin),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_ADD;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_mode <= mode_e'(mode);
      if (w_consume) begin
        r_carry <= w_cout;
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      r_sum   <= w_consume & w_s;
      r_valid <= w_consume;
      r_done  <= w_last;
      if (w_last) begin
        r_cout <= w_cout;
        // r_carry still holds the carry into the MSB here.
        r_ovf  <= r_carry ^ w_cout;
      end
    end
  end

  assign sum_out   = r_sum;
  assign out_valid = r_valid;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu (WIDTH=8): the driver pushes one expected
// entry per result bit, the monitor pops on every out_valid cycle.
module tb_serial_alu;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       a_in;
  logic       b_in;
  logic       sum_out;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic       carry_out;
  logic       overflow;

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .a_in      (a_in),
    .b_in      (b_in),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s;
    bit d;
    bit c;
    bit v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: plain unsigned/signed arithmetic on W-bit values.
  function automatic void model(input int m, input int a, input int b,
                                output int r, output bit c, output bit v);
    int sa, sb, s, full;
    full = 1 << W;
    sa = (a >= full / 2) ? a - full : a;
    sb = (b >= full / 2) ? b - full : b;
    case (m)
      0:       begin r = (a + b) % full;        c = (a + b) >= full; s = sa + sb; end
      1:       begin r = (a - b + full) % full; c = (a >= b);        s = sa - sb; end
      2:       begin r = (a + 1) % full;        c = (a == full - 1); s = sa + 1;  end
      default: begin r = (full - a) % full;     c = (a == 0);        s = -sa;     end
    endcase
    v = (s > full / 2 - 1) || (s < -(full / 2));
  endfunction

  task automatic push_word(input int m, input int a, input int b, input int n);
    int r;
    bit c, v;
    exp_t e;
    model(m, a, b, r, c, v);
    for (int i = 0; i < n; i++) begin
      e.s = bit'((r >> i) & 1);
      e.d = (i == W - 1);
      e.c = c;
      e.v = v;
      q.push_back(e);
    end
  endtask

  // Called just after a rising edge; that cycle becomes the accept cycle.
  // Mode is scrambled every cycle mid-word, and with glitch set start is
  // also toggled while busy; both must be ignored.
  task automatic run_word(input int m, input int a, input int b, input bit glitch);
    push_word(m, a, b, W);
    start = 1'b1;
    mode  = 2'(m);
    a_in  = a[0];
    b_in  = b[0];
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      check("busy_mid_word", busy, 1);
      check("valid_mid_word", out_valid, 1);
      start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      mode  = 2'($urandom_range(0, 3));
      a_in  = a[i];
      b_in  = b[i];
    end
    @(posedge clk); #1;
    check("busy_at_done", busy, 0);
    check("done_cycle", done, 1);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("sum_bit", sum_out, e.s);
          check("done_flag", done, e.d);
          if (e.d) begin
            check("carry_out", carry_out, e.c);
            check("overflow", overflow, e.v);
          end
        end
      end else begin
        check("sum_zero_idle", sum_out, 0);
        check("done_idle", done, 0);
      end
    end
  end

  initial begin
    int m, a, b, gap;
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    a_in  = 1'b0;
    b_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed words, each starting on the done cycle of the previous one.
    run_word(0, 'h5A, 'h3C, 1'b0);
    run_word(1, 'h10, 'h20, 1'b0);
    run_word(2, 'hFF, 'h00, 1'b0);
    run_word(3, 'h80, 'h00, 1'b0);
    run_word(3, 'h01, 'h55, 1'b0);
    run_word(0, 'h5A, 'h3C, 1'b1);
    @(posedge clk); #1;
    run_word(0, 'h01, 'h01, 1'b0);
    run_word(1, 'h03, 'h01, 1'b0);
    @(posedge clk); #1;
    check("idle_after_b2b", out_valid, 0);

    for (int k = 0; k < 40; k++) begin
      m   = int'($urandom_range(0, 3));
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      run_word(m, a, b, 1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    // Reset in cycle 4 of a word: bits 0..3 appear, then everything clears.
    @(posedge clk); #1;
    a = 'hC3;
    b = 'h7E;
    push_word(0, a, b, 4);
    start = 1'b1;
    mode  = 2'd0;
    a_in  = a[0];
    b_in  = b[0];
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a_in  = a[i];
      b_in  = b[i];
    end
    @(posedge clk); #1;
    reset = 1'b1;
    a_in  = a[4];
    b_in  = b[4];
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_sum", sum_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_carry", carry_out, 0);
    check("midrst_ovf", overflow, 0);
    run_word(2, 'h7F, 'h00, 1'b0);

    // Reset wins over a simultaneous start.
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_valid", out_valid, 0);
    @(posedge clk); #1;
    check("rst_prio_idle", busy, 0);
    run_word(1, 'h00, 'h01, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
